// File: rtl/bdi_pkg.sv
// Shared types and tables for the BDI line compressor.
//   - bdi_code_e  : encoding codes (0..7 candidates, 15 uncompressed)
//   - bdi_state_e : controller states
//   - code_size / code_base_bytes / code_delta_bytes : per-code constant tables
//   - elem_count / get_elem / pack_bdi : element access and payload packing helpers
package bdi_pkg;

  localparam int unsigned LINE_BITS  = 256;
  localparam int unsigned LINE_BYTES = 32;

  typedef enum logic [3:0] {
    EncZeros  = 4'd0,
    EncRep8   = 4'd1,
    EncB8d1   = 4'd2,
    EncB4d1   = 4'd3,
    EncB8d2   = 4'd4,
    EncB2d1   = 4'd5,
    EncB4d2   = 4'd6,
    EncB8d4   = 4'd7,
    EncUncomp = 4'd15
  } bdi_code_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEval = 2'd1,
    StPack = 2'd2,
    StOut  = 2'd3
  } bdi_state_e;

  function automatic logic [5:0] code_size(input bdi_code_e c);
    case (c)
      EncZeros: return 6'd1;
      EncRep8:  return 6'd8;
      EncB8d1:  return 6'd12;
      EncB4d1:  return 6'd12;
      EncB8d2:  return 6'd16;
      EncB2d1:  return 6'd18;
      EncB4d2:  return 6'd20;
      EncB8d4:  return 6'd24;
      default:  return 6'd32;
    endcase
  endfunction

  // Non-BxDy codes map to harmless widths so a shared checker never sees zero.
  function automatic logic [3:0] code_base_bytes(input bdi_code_e c);
    case (c)
      EncB4d1, EncB4d2: return 4'd4;
      EncB2d1:          return 4'd2;
      default:          return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] code_delta_bytes(input bdi_code_e c);
    case (c)
      EncB8d2, EncB4d2: return 4'd2;
      EncB8d4:          return 4'd4;
      default:          return 4'd1;
    endcase
  endfunction

  function automatic int unsigned elem_count(input logic [3:0] bb);
    case (bb)
      4'd2:    return 16;
      4'd4:    return 8;
      default: return 4;
    endcase
  endfunction

  // Element idx of width bb bytes, zero-extended to 64 bits.
  function automatic logic [63:0] get_elem(input logic [LINE_BITS-1:0] l, input logic [3:0] bb,
                                           input int unsigned idx);
    logic [63:0] e;
    int unsigned xb;
    xb = 32'(bb);
    e  = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (b < xb && (xb * idx + b) < LINE_BYTES) e[8*b +: 8] = l[8*(xb*idx + b) +: 8];
    end
    return e;
  endfunction

  // Base in the low bb bytes, then each delta truncated to db bytes in element order.
  function automatic logic [LINE_BITS-1:0] pack_bdi(input logic [LINE_BITS-1:0] l,
                                                   input logic [3:0] bb, input logic [3:0] db);
    logic [LINE_BITS-1:0] p;
    logic [63:0] base, d;
    int unsigned xb, yb, pos;
    xb   = 32'(bb);
    yb   = 32'(db);
    p    = '0;
    base = get_elem(l, bb, 0);
    for (int unsigned b = 0; b < 8; b++) begin
      if (b < xb) p[8*b +: 8] = base[8*b +: 8];
    end
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < elem_count(bb)) begin
        d = get_elem(l, bb, i) - base;
        for (int unsigned b = 0; b < 4; b++) begin
          pos = xb + i * yb + b;
          if (b < yb && pos < LINE_BYTES) p[8*pos +: 8] = d[8*b +: 8];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bdi_line_compressor_if.sv
// Handshake bundle between the cache controller and the BDI compressor.
//   input channel : in_valid/in_ready with in_line, in_index, in_tag
//   output channel: out_valid/out_ready with out_code, out_size, out_payload, out_index, out_tag
// master = controller side, slave = compressor side.
interface bdi_line_compressor_if #(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned TAG_FIELD   = 20
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LINE_WIDTH-1:0]  in_line;
  logic [INDEX_WIDTH-1:0] in_index;
  logic [TAG_FIELD-1:0]   in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [3:0]             out_code;
  logic [5:0]             out_size;
  logic [LINE_WIDTH-1:0]  out_payload;
  logic [INDEX_WIDTH-1:0] out_index;
  logic [TAG_FIELD-1:0]   out_tag;

  modport master (
    output in_valid, in_line, in_index, in_tag, out_ready,
    input  in_ready, out_valid, out_code, out_size, out_payload, out_index, out_tag
  );

  modport slave (
    input  in_valid, in_line, in_index, in_tag, out_ready,
    output in_ready, out_valid, out_code, out_size, out_payload, out_index, out_tag
  );
endinterface

// File: rtl/bdi_fit_check.sv
// Combinational BxDy fit test over a full 256-bit line.
//   line        : line data
//   base_bytes  : element/base width x in bytes (2, 4 or 8)
//   delta_bytes : delta width y in bytes (1, 2 or 4)
//   fit         : every (e_i - base) mod 2^(8x) is representable as a signed y-byte value
module bdi_fit_check
  import bdi_pkg::*;
(
  input  logic [LINE_BITS-1:0] line,
  input  logic [3:0]           base_bytes,
  input  logic [3:0]           delta_bytes,
  output logic                 fit
);

  function automatic logic fits(input logic [LINE_BITS-1:0] l, input logic [3:0] bb,
                                input logic [3:0] db);
    int unsigned xb, yb;
    logic [5:0]  sb;
    logic [63:0] base, d;
    logic        ok;
    xb   = 32'(bb);
    yb   = (db == 4'd0) ? 32'd1 : 32'(db);
    sb   = 6'(8 * yb - 1);
    base = get_elem(l, bb, 0);
    ok   = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < elem_count(bb)) begin
        d = get_elem(l, bb, i) - base;
        // Bits between the delta sign bit and the element width must all copy the sign.
        for (int unsigned b = 0; b < 64; b++) begin
          if (b >= 8 * yb && b < 8 * xb && d[b] != d[sb]) ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

  assign fit = fits(line, base_bytes, delta_bytes);

endmodule

// File: rtl/bdi_line_compressor.sv
// Base-Delta-Immediate line compressor: accepts one line, picks the smallest fitting
// encoding, packs the payload and presents it until the consumer accepts.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of bdi_line_compressor_if (input and output handshakes)
// Build option BDI_PARALLEL_EVAL_EN: evaluate all candidates in one cycle (fixed latency);
// otherwise candidates are tried serially with one shared checker.
module bdi_line_compressor
  import bdi_pkg::*;
#(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned TAG_FIELD   = 20
) (
  input logic                  clk,
  input logic                  rst,
  bdi_line_compressor_if.slave bus
);

  bdi_state_e             state_q, state_d;
  bdi_code_e              code_q, code_d;
  logic [LINE_WIDTH-1:0]  line_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [TAG_FIELD-1:0]   tag_q;

  bdi_code_e              out_code_q;
  logic [5:0]             out_size_q;
  logic [LINE_WIDTH-1:0]  out_payload_q, payload_d;
  logic [INDEX_WIDTH-1:0] out_index_q;
  logic [TAG_FIELD-1:0]   out_tag_q;

  logic      accept;
  logic      line_zero, line_rep8;
  logic      eval_fit, eval_last;
  bdi_code_e eval_code;

  assign accept    = (state_q == StIdle) && bus.in_valid;
  assign line_zero = (line_q == '0);
  assign line_rep8 = (line_q[63:0] == line_q[127:64]) && (line_q[63:0] == line_q[191:128]) &&
                     (line_q[63:0] == line_q[255:192]);

`ifdef BDI_PARALLEL_EVAL_EN
  logic [7:0] fits;

  assign fits[0] = line_zero;
  assign fits[1] = line_rep8;

  for (genvar c = 2; c < 8; c++) begin : g_cand
    bdi_fit_check u_fit (
      .line        (line_q),
      .base_bytes  (code_base_bytes(bdi_code_e'(4'(c)))),
      .delta_bytes (code_delta_bytes(bdi_code_e'(4'(c)))),
      .fit         (fits[c])
    );
  end

  // Lowest fitting code wins; UNCOMP when nothing fits.
  always_comb begin
    eval_fit  = 1'b1;
    eval_last = 1'b1;
    eval_code = EncUncomp;
    for (int c = 7; c >= 0; c--) begin
      if (fits[c]) eval_code = bdi_code_e'(4'(c));
    end
  end
`else
  logic [2:0] k_q, k_d;
  bdi_code_e  k_code;
  logic       chk_fit;

  assign k_code = bdi_code_e'({1'b0, k_q});

  bdi_fit_check u_fit (
    .line        (line_q),
    .base_bytes  (code_base_bytes(k_code)),
    .delta_bytes (code_delta_bytes(k_code)),
    .fit         (chk_fit)
  );

  always_comb begin
    eval_code = k_code;
    eval_last = (k_q == 3'd7);
    unique case (k_q)
      3'd0:    eval_fit = line_zero;
      3'd1:    eval_fit = line_rep8;
      default: eval_fit = chk_fit;
    endcase
  end

  always_comb begin
    k_d = k_q;
    if (state_q == StIdle) begin
      k_d = '0;
    end else if (state_q == StEval && !eval_fit) begin
      k_d = k_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) k_q <= '0;
    else      k_q <= k_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: if (bus.in_valid) state_d = StEval;
      StEval: begin
        if (eval_fit) begin
          code_d  = eval_code;
          state_d = StPack;
        end else if (eval_last) begin
          code_d  = EncUncomp;
          state_d = StPack;
        end
      end
      StPack: state_d = StOut;
      StOut:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    payload_d = '0;
    case (code_q)
      EncZeros:  payload_d = '0;
      EncRep8:   payload_d[63:0] = line_q[63:0];
      EncUncomp: payload_d = line_q;
      default:   payload_d = pack_bdi(line_q, code_base_bytes(code_q), code_delta_bytes(code_q));
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      code_q  <= EncZeros;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q  <= '0;
      index_q <= '0;
      tag_q   <= '0;
    end else if (accept) begin
      line_q  <= bus.in_line;
      index_q <= bus.in_index;
      tag_q   <= bus.in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_code_q    <= EncZeros;
      out_size_q    <= '0;
      out_payload_q <= '0;
      out_index_q   <= '0;
      out_tag_q     <= '0;
    end else if (state_q == StPack) begin
      out_code_q    <= code_q;
      out_size_q    <= code_size(code_q);
      out_payload_q <= payload_d;
      out_index_q   <= index_q;
      out_tag_q     <= tag_q;
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = (state_q == StOut);
  assign bus.out_code    = out_code_q;
  assign bus.out_size    = out_size_q;
  assign bus.out_payload = out_payload_q;
  assign bus.out_index   = out_index_q;
  assign bus.out_tag     = out_tag_q;

endmodule
